// File: rtl/ctrl_fsm.sv
// rtl/ctrl_fsm.sv - multi-cycle fetch/decode/sequence control for the 16-bit accumulator datapath
module ctrl_fsm #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic [3:0] Opcode,
    input  logic       Zero,
    input  logic       MemReady,
    output logic [1:0] SrcA,
    output logic [2:0] SrcB,
    output logic [2:0] ALUOP,
    output logic [1:0] AddrSel,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MDRWrite,
    output logic       PCWrite,
    output logic       PCSrc,
    output logic       SPWrite,
    output logic       AccWrite,
    output logic       AccSrc,
    output logic       Halted,
    output logic       Trap
);

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMRD,
        S_EXALU,
        S_WBALU,
        S_WBMEM,
        S_MEMWR,
        S_BRANCH,
        S_JUMP,
        S_SPDEC,
        S_HALT,
        S_TRAP
    } state_t;

    typedef struct packed {
        logic [1:0] srca;
        logic [2:0] srcb;
        logic [2:0] aluop;
        logic [1:0] addrsel;
        logic       memread;
        logic       memwrite;
        logic       irwrite;
        logic       mdrwrite;
        logic       pcwrite;
        logic       pcsrc;
        logic       spwrite;
        logic       accwrite;
        logic       accsrc;
        logic       halted;
        logic       trap;
    } ctl_t;

    localparam logic [1:0] SRCA_PC   = 2'd0;
    localparam logic [1:0] SRCA_ACC  = 2'd1;
    localparam logic [1:0] SRCA_SP   = 2'd2;
    localparam logic [2:0] SRCB_TWO  = 3'd0;
    localparam logic [2:0] SRCB_SE   = 3'd1;
    localparam logic [2:0] SRCB_MDR  = 3'd2;
    localparam logic [2:0] SRCB_ZE   = 3'd3;
    localparam logic [2:0] SRCB_SL1  = 3'd4;
    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_PASSA = 3'd5;
    localparam logic [2:0] ALU_PASSB = 3'd6;
    localparam logic [1:0] ADDR_PC   = 2'd0;
    localparam logic [1:0] ADDR_ZE   = 2'd1;
    localparam logic [1:0] ADDR_SP   = 2'd2;
    localparam logic [1:0] ADDR_ALU  = 2'd3;

    localparam logic [3:0] OP_LDA  = 4'h4;
    localparam logic [3:0] OP_STA  = 4'h5;
    localparam logic [3:0] OP_ADDI = 4'h6;
    localparam logic [3:0] OP_BEQZ = 4'h7;
    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_PUSH = 4'h9;
    localparam logic [3:0] OP_POP  = 4'hA;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT - 1);

    state_t      state;
    state_t      state_nx;
    logic [15:0] wait_cnt;
    logic [15:0] wait_cnt_nx;
    logic        mem_state;
    logic        wait_expired;
    logic        alu_mem_op;
    ctl_t        ctl;
    ctl_t        ctl_out;

    assign mem_state    = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
    assign wait_expired = mem_state && !MemReady && (wait_cnt == LAST_WAIT);
    assign alu_mem_op   = (Opcode[3:2] == 2'b00);

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_FETCH:  if (MemReady) state_nx = S_DECODE;
            S_DECODE: begin
                unique case (Opcode)
                    4'h0, 4'h1, 4'h2, 4'h3,
                    OP_LDA, OP_POP: state_nx = S_MEMRD;
                    OP_STA:         state_nx = S_MEMWR;
                    OP_ADDI:        state_nx = S_EXALU;
                    OP_BEQZ:        state_nx = S_BRANCH;
                    OP_JMP:         state_nx = S_JUMP;
                    OP_PUSH:        state_nx = S_SPDEC;
                    OP_HALT:        state_nx = S_HALT;
                    default:        state_nx = S_TRAP;
                endcase
            end
            S_MEMRD:  if (MemReady) state_nx = alu_mem_op ? S_EXALU : S_WBMEM;
            S_EXALU:  state_nx = S_WBALU;
            S_WBALU:  state_nx = S_FETCH;
            S_WBMEM:  state_nx = S_FETCH;
            S_MEMWR:  if (MemReady) state_nx = S_FETCH;
            S_BRANCH: state_nx = S_FETCH;
            S_JUMP:   state_nx = S_FETCH;
            S_SPDEC:  state_nx = S_MEMWR;
            S_HALT:   state_nx = S_HALT;
            S_TRAP:   state_nx = S_TRAP;
            default:  state_nx = S_TRAP;
        endcase
        if (wait_expired) begin
            state_nx = S_TRAP;
        end
    end

    // Counter only runs while a memory state is being stretched; any state change restarts it.
    always_comb begin
        wait_cnt_nx = '0;
        if (mem_state && !MemReady && (state_nx == state)) begin
            wait_cnt_nx = 16'(wait_cnt + 16'd1);
        end
    end

    always_comb begin
        ctl = '0;
        unique case (state)
            S_FETCH: begin
                ctl.addrsel = ADDR_PC;
                ctl.memread = 1'b1;
                ctl.srca    = SRCA_PC;
                ctl.srcb    = SRCB_TWO;
                ctl.aluop   = ALU_ADD;
                ctl.irwrite = MemReady;
                ctl.pcwrite = MemReady;
                ctl.pcsrc   = 1'b0;
            end
            S_DECODE: begin
                ctl.srca  = SRCA_PC;
                ctl.srcb  = SRCB_SL1;
                ctl.aluop = ALU_ADD;
            end
            S_MEMRD: begin
                ctl.memread  = 1'b1;
                ctl.mdrwrite = 1'b1;
                ctl.addrsel  = (Opcode == OP_POP) ? ADDR_SP : ADDR_ZE;
            end
            S_EXALU: begin
                ctl.srca = SRCA_ACC;
                if (alu_mem_op) begin
                    ctl.srcb  = SRCB_MDR;
                    ctl.aluop = {1'b0, Opcode[1:0]};
                end else if (Opcode == OP_ADDI) begin
                    ctl.srcb  = SRCB_SE;
                    ctl.aluop = ALU_ADD;
                end
            end
            S_WBALU: begin
                ctl.accwrite = 1'b1;
                ctl.accsrc   = 1'b1;
            end
            S_WBMEM: begin
                ctl.accwrite = 1'b1;
                ctl.accsrc   = 1'b0;
                if (Opcode == OP_POP) begin
                    ctl.srca    = SRCA_SP;
                    ctl.srcb    = SRCB_TWO;
                    ctl.aluop   = ALU_ADD;
                    ctl.spwrite = 1'b1;
                end
            end
            S_MEMWR: begin
                ctl.memwrite = 1'b1;
                ctl.addrsel  = (Opcode == OP_PUSH) ? ADDR_ALU : ADDR_ZE;
            end
            S_BRANCH: begin
                ctl.srca    = SRCA_ACC;
                ctl.aluop   = ALU_PASSA;
                ctl.pcwrite = Zero;
                ctl.pcsrc   = 1'b1;
            end
            S_JUMP: begin
                ctl.srcb    = SRCB_ZE;
                ctl.aluop   = ALU_PASSB;
                ctl.pcwrite = 1'b1;
                ctl.pcsrc   = 1'b0;
            end
            S_SPDEC: begin
                ctl.srca    = SRCA_SP;
                ctl.srcb    = SRCB_TWO;
                ctl.aluop   = ALU_SUB;
                ctl.spwrite = 1'b1;
            end
            S_HALT:  ctl.halted = 1'b1;
            S_TRAP:  ctl.trap   = 1'b1;
            default: ctl.trap   = 1'b1;
        endcase
    end

    // Everything is forced quiet while reset is held, including the FETCH read request.
    assign ctl_out = Reset ? ctl : '0;

    assign SrcA     = ctl_out.srca;
    assign SrcB     = ctl_out.srcb;
    assign ALUOP    = ctl_out.aluop;
    assign AddrSel  = ctl_out.addrsel;
    assign MemRead  = ctl_out.memread;
    assign MemWrite = ctl_out.memwrite;
    assign IRWrite  = ctl_out.irwrite;
    assign MDRWrite = ctl_out.mdrwrite;
    assign PCWrite  = ctl_out.pcwrite;
    assign PCSrc    = ctl_out.pcsrc;
    assign SPWrite  = ctl_out.spwrite;
    assign AccWrite = ctl_out.accwrite;
    assign AccSrc   = ctl_out.accsrc;
    assign Halted   = ctl_out.halted;
    assign Trap     = ctl_out.trap;

endmodule
